dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the data-cache burst memory port: accepts word writes and burst-read requests, and answers with mem_out/mem_valid.
- Backed by an internal synchronous word RAM.
- Used as the main-memory model/controller behind the data cache and in cache-level benches.
- Publishes its fixed burst length on mem_burstlen so the requester sizes its bursts to match.

Parameters:
DATABITS, 32, data word width
ADDRBITS, 32, byte-address width of mem_addr
MEMADDRBITS, 10, log2 of RAM depth in words (1024 words)
BURSTLEN, 8, words returned per read request; range 1..65535
RDLATENCY, 2, cycles from accepted rdreq to first mem_valid; range 1..15

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_addr  in  ADDRBITS  byte address; bits [1:0] ignored; bits above MEMADDRBITS+1 ignored (aliasing)
mem_in  in  DATABITS  write data
mem_rdreq  in  1  burst-read request, level
mem_wrreq  in  1  single-word write strobe, one word per cycle high
mem_out  out  DATABITS  read data, registered
mem_valid  out  1  mem_out holds a burst word this cycle
mem_burstlen  out  16  constant BURSTLEN
mem_protoerr  out  1  sticky: a write was dropped during a read

Behaviour:
- Reset (async, reset_n=0): mem_out=0, mem_valid=0, mem_protoerr=0, state=IDLE, counters=0. RAM contents are not cleared.
- Reset during RDWAIT/RDBURST: mem_valid falls immediately and the burst is abandoned.
- mem_burstlen = BURSTLEN zero-extended to 16 bits, also during reset.
- Word index = mem_addr[MEMADDRBITS+1:2].
- States: IDLE, RDWAIT, RDBURST.
- IDLE:
  - mem_wrreq=1 writes mem_in to RAM[index] at that edge. State stays IDLE; no mem_valid.
  - Else if mem_rdreq=1: latch rd_ptr=index, lat_cnt=0, burst_cnt=0, go RDWAIT.
  - mem_wrreq has priority over mem_rdreq in the same cycle. A still-high rdreq is taken the next IDLE cycle.
- RDWAIT:
  - Issue the RAM read of rd_ptr and count lat_cnt.
  - After RDLATENCY-1 cycles enter RDBURST. RDLATENCY=1 means RDWAIT lasts one cycle.
  - Timing: rdreq sampled at edge T gives the first mem_valid=1 in the cycle after edge T+RDLATENCY.
- RDBURST:
  - mem_valid=1 on BURSTLEN consecutive cycles, with no gaps.
  - Word k = RAM[(rd_ptr+k) mod 2^MEMADDRBITS]; the pointer wraps from the top word to 0.
  - mem_out updates each cycle. After the last word mem_valid=0 and mem_out holds its last value; state returns to IDLE.
- mem_rdreq/mem_wrreq outside IDLE:
  - rdreq is ignored; the requester drops it on the first mem_valid.
  - A wrreq=1 outside IDLE is dropped, not written, and sets mem_protoerr=1 until reset.
- Back-to-back: rdreq high in the IDLE cycle following a burst starts a new burst with no extra bubble.
- Read-after-write: a write at edge T is visible to a read request accepted at edge T+1 or later.
- Only full-word writes; the requester performs any byte merging.

Decomposition:
- Shared package (dmem_pkg): state encoding (IDLE=2'b00, RDWAIT=2'b01, RDBURST=2'b10), default BURSTLEN/RDLATENCY constants.
- Sub-module dmem_ram:
  - single-port synchronous RAM, DATABITS x 2^MEMADDRBITS.
  - inputs: we, addr, din; registered dout (1-cycle read).
  - holds no reset logic, so it maps to block RAM.
- Top level holds the FSM, counters, pointer wrap and error flag.

Test Plan:
1. Write 0x11111111..0x88888888 to byte addrs 0x000..0x01C, then rdreq at addr 0x000 (defaults) -> mem_valid high 8 consecutive cycles starting 3 cycles after the rdreq edge, data 0x11111111..0x88888888 in order, mem_burstlen=8.
2. Write words at word indexes 1022, 1023, 0, 1; rdreq at byte addr 0xFF8 -> returns those four words in order, crossing the wrap at index 1023->0.
3. Same cycle mem_wrreq=1 (addr 0x40, data 0xDEADBEEF) and mem_rdreq=1 (addr 0x40), rdreq held -> write taken first; burst begins one cycle later, first word 0xDEADBEEF.
4. mem_wrreq=1 during RDBURST at addr 0x80 -> RAM[0x20] unchanged on readback, mem_protoerr=1 and stays 1 until reset_n=0.
5. Assert reset_n=0 mid-burst (after word 3) -> mem_valid=0 immediately, mem_out=0. After release a fresh rdreq returns a full 8-word burst with pre-reset RAM data intact.
6. RDLATENCY=1, BURSTLEN=1, rdreq held high continuously -> single-word bursts on consecutive requests; a new mem_valid every 3 cycles (IDLE, RDWAIT, RDBURST).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default timing constants.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RDWAIT  = 2'b01,
    ST_RDBURST = 2'b10
  } state_e;

  localparam int unsigned DEF_BURSTLEN  = 8;
  localparam int unsigned DEF_RDLATENCY = 2;
  localparam int unsigned LAT_W         = 4;
  localparam int unsigned BCNT_W        = 16;

endpackage

// File: rtl/dmem_responder_if.sv
// Burst memory port between the data cache (master) and the memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned DATABITS = 32,
  parameter int unsigned ADDRBITS = 32
);

  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_in;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic [DATABITS-1:0] mem_out;
  logic                mem_valid;
  logic [15:0]         mem_burstlen;
  logic                mem_protoerr;

  modport master (
    output mem_addr, mem_in, mem_rdreq, mem_wrreq,
    input  mem_out, mem_valid, mem_burstlen, mem_protoerr
  );

  modport slave (
    input  mem_addr, mem_in, mem_rdreq, mem_wrreq,
    output mem_out, mem_valid, mem_burstlen, mem_protoerr
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with registered read data; no reset so it maps to block RAM.
module dmem_ram #(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned MEMADDRBITS = 10
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [MEMADDRBITS-1:0] addr_i,
  input  logic [DATABITS-1:0]    din_i,
  output logic [DATABITS-1:0]    dout_o
);

  localparam int unsigned DEPTH = 2 ** MEMADDRBITS;

  logic [DATABITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: single-word writes in IDLE, fixed-length read bursts after a fixed latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned ADDRBITS    = 32,
  parameter int unsigned MEMADDRBITS = 10,
  parameter int unsigned BURSTLEN    = DEF_BURSTLEN,
  parameter int unsigned RDLATENCY   = DEF_RDLATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_responder_if.slave   bus
);

  // RAM reads are one cycle ahead of mem_out; word 0 is fetched in the last-but-one
  // cycle before the burst, which for a latency of 1 is the accepting IDLE cycle itself.
  localparam logic [LAT_W-1:0]       LAT_LAST    = LAT_W'(RDLATENCY - 1);
  localparam logic [LAT_W-1:0]       FETCH_FIRST = LAT_W'((RDLATENCY > 1) ? (RDLATENCY - 2) : 0);
  localparam logic [MEMADDRBITS-1:0] PTR_SKIP    = MEMADDRBITS'((RDLATENCY == 1) ? 1 : 0);
  localparam logic [BCNT_W-1:0]      BURST_LAST  = BCNT_W'(BURSTLEN - 1);

  state_e                  state_q, state_d;
  logic [MEMADDRBITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [BCNT_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic [DATABITS-1:0]     mem_out_q;
  logic                    mem_valid_q;
  logic                    protoerr_q, protoerr_d;

  logic [MEMADDRBITS-1:0]  index_c;
  logic [MEMADDRBITS-1:0]  ram_addr_c;
  logic                    ram_we_c;
  logic [DATABITS-1:0]     ram_dout;
  logic                    unused_addr_c;

  assign index_c       = bus.mem_addr[MEMADDRBITS+1:2];
  assign unused_addr_c = ^{bus.mem_addr[ADDRBITS-1:MEMADDRBITS+2], bus.mem_addr[1:0]};

  dmem_ram #(
    .DATABITS    (DATABITS),
    .MEMADDRBITS (MEMADDRBITS)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we_c),
    .addr_i (ram_addr_c),
    .din_i  (bus.mem_in),
    .dout_o (ram_dout)
  );

  // Next-state, RAM control and fetch-pointer logic.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    protoerr_d  = protoerr_q;
    ram_we_c    = 1'b0;
    ram_addr_c  = rd_ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        ram_addr_c = index_c;
        if (bus.mem_wrreq) begin
          ram_we_c = 1'b1;
        end else if (bus.mem_rdreq) begin
          rd_ptr_d    = index_c + PTR_SKIP;
          lat_cnt_d   = '0;
          burst_cnt_d = '0;
          state_d     = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        if ((lat_cnt_q == FETCH_FIRST) || (lat_cnt_q == LAT_LAST)) begin
          rd_ptr_d = rd_ptr_q + MEMADDRBITS'(1);
        end
        if (lat_cnt_q == LAT_LAST) begin
          state_d = ST_RDBURST;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_RDBURST: begin
        rd_ptr_d = rd_ptr_q + MEMADDRBITS'(1);
        if (burst_cnt_q == BURST_LAST) begin
          state_d = ST_IDLE;
        end else begin
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Writes arriving while a read is in flight are dropped and flagged.
    if ((state_q != ST_IDLE) && bus.mem_wrreq) begin
      protoerr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      lat_cnt_q   <= '0;
      burst_cnt_q <= '0;
      mem_out_q   <= '0;
      mem_valid_q <= 1'b0;
      protoerr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      protoerr_q  <= protoerr_d;
      mem_valid_q <= (state_d == ST_RDBURST);
      if (state_d == ST_RDBURST) begin
        mem_out_q <= ram_dout;
      end
    end
  end

  assign bus.mem_out      = mem_out_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_protoerr = protoerr_q;
  assign bus.mem_burstlen = 16'(BURSTLEN);

endmodule
